// File: rtl/fmdll_lock_ctrl.sv
// rtl/fmdll_lock_ctrl.sv - FMDLL lock controller: SAR coarse search, +/-1 tracking, lock and fault reporting
module fmdll_lock_ctrl #(
   parameter int CODE_W    = 6,
   parameter int N_W       = 4,
   parameter int M_W       = 2,
   parameter int N_MAX     = 10,
   parameter int SETTLE    = 3,
   parameter int LOCK_CNT  = 8,
   parameter int UNLOCK_TH = 3
) (
   input  logic              clk_ext,
   input  logic              rst_n,
   input  logic [N_W-1:0]    N,
   input  logic [M_W-1:0]    M,
   input  logic              pd_up,
   input  logic              pd_dn,
   input  logic              freeze,
   output logic [CODE_W-1:0] dly_code,
   output logic [M_W-1:0]    Sel,
   output logic              locked,
   output logic              busy,
   output logic              err_cfg,
   output logic              err_range
);
   localparam int TMR_W = $clog2(SETTLE + 2);
   localparam int BIT_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
   localparam int CNT_W = $clog2(LOCK_CNT + 1);
   localparam int RUN_W = $clog2(UNLOCK_TH + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SETTLE);
   localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(CODE_W - 1);
   localparam logic [CNT_W-1:0] CNT_LOCK = CNT_W'(LOCK_CNT);
   localparam logic [RUN_W-1:0] RUN_TH   = RUN_W'(UNLOCK_TH);
   localparam logic [N_W-1:0]   N_LIM    = N_W'(N_MAX);

   typedef enum logic [2:0] {S_IDLE, S_SAR, S_TRACK, S_LOCKED, S_FAULT} state_t;
   typedef enum logic [1:0] {D_NONE, D_UP, D_DN} dir_t;

   state_t            r_state;
   dir_t              r_last_dir;
   logic              r_latched;
   logic [N_W-1:0]    r_n_q;
   logic [M_W-1:0]    r_m_q;
   logic [TMR_W-1:0]  r_tmr;
   logic [BIT_W-1:0]  r_bit;
   logic [CODE_W-1:0] r_code;
   logic [M_W-1:0]    r_sel;
   logic              r_locked, r_busy, r_err_cfg, r_err_range;
   logic [CNT_W-1:0]  r_lock_cnt;
   logic [RUN_W-1:0]  r_run, r_sat;

   logic              w_cfg_chg, w_cfg_ok, w_sample, w_up, w_dn, w_sat, w_move, w_good;
   dir_t              w_dir;
   logic [CODE_W-1:0] w_bit_mask, w_sar_code, w_step_code;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [RUN_W-1:0]  w_run_nxt, w_sat_nxt;
   logic [M_W-1:0]    w_sel_nxt;

   assign w_cfg_chg   = (N != r_n_q) || (M != r_m_q);
   assign w_cfg_ok    = (r_n_q != '0) && (r_n_q <= N_LIM) && (r_m_q != '0);
   assign w_sample    = (r_tmr == TMR_LAST);
   assign w_up        = pd_up & ~pd_dn;
   assign w_dn        = pd_dn & ~pd_up;
   // A request past either end is a saturation event, not a move.
   assign w_sat       = (w_up & (&r_code)) | (w_dn & ~(|r_code));
   assign w_move      = (w_up | w_dn) & ~w_sat;
   assign w_dir       = w_up ? D_UP : D_DN;
   assign w_good      = ~w_move | (w_dir != r_last_dir);
   assign w_cnt_nxt   = w_good ? r_lock_cnt + CNT_W'(1) : '0;
   assign w_run_nxt   = !w_move ? '0 :
                        (w_dir != r_last_dir) ? RUN_W'(1) :
                        (r_run == RUN_TH) ? r_run : r_run + RUN_W'(1);
   assign w_sat_nxt   = r_sat + RUN_W'(1);
   assign w_step_code = w_up ? r_code + CODE_W'(1) : r_code - CODE_W'(1);
   assign w_bit_mask  = CODE_W'(1) << r_bit;
   assign w_sar_code  = (w_up ? r_code : (r_code & ~w_bit_mask)) | (w_bit_mask >> 1);
   assign w_sel_nxt   = (M == '0) ? '0 : M - M_W'(1);

   always_ff @(posedge clk_ext or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_last_dir  <= D_NONE;
         r_latched   <= 1'b0;
         r_n_q       <= '0;
         r_m_q       <= '0;
         r_tmr       <= '0;
         r_bit       <= '0;
         r_code      <= '0;
         r_sel       <= '0;
         r_locked    <= 1'b0;
         r_busy      <= 1'b0;
         r_err_cfg   <= 1'b0;
         r_err_range <= 1'b0;
         r_lock_cnt  <= '0;
         r_run       <= '0;
         r_sat       <= '0;
      end else if (r_state != S_IDLE && w_cfg_chg) begin
         // New configuration is captured here, so IDLE only has to validate it.
         r_state     <= S_IDLE;
         r_latched   <= 1'b1;
         r_n_q       <= N;
         r_m_q       <= M;
         r_sel       <= w_sel_nxt;
         r_code      <= '0;
         r_locked    <= 1'b0;
         r_busy      <= 1'b0;
         r_err_cfg   <= 1'b0;
         r_err_range <= 1'b0;
         r_tmr       <= '0;
         r_lock_cnt  <= '0;
         r_run       <= '0;
         r_sat       <= '0;
      end else if (!freeze) begin
         case (r_state)
            S_IDLE: begin
               if (!r_latched) begin
                  r_latched <= 1'b1;
                  r_n_q     <= N;
                  r_m_q     <= M;
                  r_sel     <= w_sel_nxt;
               end else begin
                  r_latched <= 1'b0;
                  if (w_cfg_ok) begin
                     r_state    <= S_SAR;
                     r_code     <= CODE_W'(1) << (CODE_W - 1);
                     r_bit      <= BIT_TOP;
                     r_busy     <= 1'b1;
                     r_tmr      <= '0;
                     r_last_dir <= D_NONE;
                     r_lock_cnt <= '0;
                     r_run      <= '0;
                     r_sat      <= '0;
                  end else begin
                     r_state   <= S_FAULT;
                     r_err_cfg <= 1'b1;
                  end
               end
            end
            S_SAR: begin
               if (!w_sample) begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end else begin
                  r_tmr  <= '0;
                  r_code <= w_sar_code;
                  if (r_bit == '0) r_state <= S_TRACK;
                  else             r_bit   <= r_bit - BIT_W'(1);
               end
            end
            S_TRACK, S_LOCKED: begin
               if (!w_sample) begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end else begin
                  r_tmr <= '0;
                  if (w_sat) begin
                     r_sat <= w_sat_nxt;
                     if (w_sat_nxt == RUN_TH) begin
                        r_state     <= S_FAULT;
                        r_err_range <= 1'b1;
                        r_busy      <= 1'b0;
                        r_locked    <= 1'b0;
                     end
                  end else begin
                     r_sat <= '0;
                     r_run <= w_run_nxt;
                     if (w_move) begin
                        r_code     <= w_step_code;
                        r_last_dir <= w_dir;
                     end
                     if (r_state == S_TRACK) begin
                        r_lock_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == CNT_LOCK) begin
                           r_state  <= S_LOCKED;
                           r_locked <= 1'b1;
                           r_busy   <= 1'b0;
                        end
                     end else if (w_run_nxt >= RUN_TH) begin
                        r_state    <= S_TRACK;
                        r_locked   <= 1'b0;
                        r_busy     <= 1'b1;
                        r_lock_cnt <= '0;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign dly_code  = r_code;
   assign Sel       = r_sel;
   assign locked    = r_locked;
   assign busy      = r_busy;
   assign err_cfg   = r_err_cfg;
   assign err_range = r_err_range;
endmodule

// File: tb/tb_fmdll_lock_ctrl.sv
// tb/tb_fmdll_lock_ctrl.sv - randomized bench for fmdll_lock_ctrl against a behavioural lock model
module tb_fmdll_lock_ctrl;
   logic       clk_ext = 1'b0;
   logic       rst_n   = 1'b1;
   logic [3:0] N       = 4'd10;
   logic [1:0] M       = 2'd3;
   logic       pd_up   = 1'b0;
   logic       pd_dn   = 1'b0;
   logic       freeze  = 1'b0;
   logic [5:0] dly_code;
   logic [1:0] Sel;
   logic       locked, busy, err_cfg, err_range;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;
   int pd_mode = 0;
   int tgt     = 37;
   int saved;

   // expected outputs
   int e_code, e_sel, e_locked, e_busy, e_errc, e_errr;
   // model bookkeeping: phase 0 latch, 1 validate, 2 sar, 3 track, 4 locked, 5 fault
   int m_ph, m_nq, m_mq, m_cyc, m_bit, m_cnt, m_run, m_sat, m_last;

   fmdll_lock_ctrl dut (
      .clk_ext  (clk_ext),
      .rst_n    (rst_n),
      .N        (N),
      .M        (M),
      .pd_up    (pd_up),
      .pd_dn    (pd_dn),
      .freeze   (freeze),
      .dly_code (dly_code),
      .Sel      (Sel),
      .locked   (locked),
      .busy     (busy),
      .err_cfg  (err_cfg),
      .err_range(err_range)
   );

   always #5 clk_ext = ~clk_ext;

   task automatic model_reset();
      e_code = 0; e_sel = 0; e_locked = 0; e_busy = 0; e_errc = 0; e_errr = 0;
      m_ph = 0; m_nq = 0; m_mq = 0; m_cyc = 0; m_bit = 0;
      m_cnt = 0; m_run = 0; m_sat = 0; m_last = 0;
   endtask

   task automatic model_step();
      int req;
      bit good;
      if (m_ph >= 2 && (int'(N) != m_nq || int'(M) != m_mq)) begin
         m_ph = 1; m_nq = N; m_mq = M; e_sel = (M == 0) ? 0 : M - 1;
         e_code = 0; e_locked = 0; e_busy = 0; e_errc = 0; e_errr = 0;
         m_cyc = 0; m_cnt = 0; m_run = 0; m_sat = 0;
         return;
      end
      if (freeze) return;
      case (m_ph)
         0: begin m_nq = N; m_mq = M; e_sel = (M == 0) ? 0 : M - 1; m_ph = 1; end
         1: begin
            if (m_nq >= 1 && m_nq <= 10 && m_mq >= 1) begin
               m_ph = 2; e_code = 32; e_busy = 1; m_bit = 5; m_cyc = 0;
               m_cnt = 0; m_run = 0; m_sat = 0; m_last = 0;
            end else begin
               m_ph = 5; e_errc = 1;
            end
         end
         2: begin
            if (m_cyc < 3) m_cyc++;
            else begin
               m_cyc = 0;
               if (!(pd_up && !pd_dn)) e_code -= (1 << m_bit);
               if (m_bit > 0) begin m_bit--; e_code += (1 << m_bit); end
               else m_ph = 3;
            end
         end
         3, 4: begin
            if (m_cyc < 3) begin m_cyc++; return; end
            m_cyc = 0;
            req = (pd_up && !pd_dn) ? 1 : (pd_dn && !pd_up) ? -1 : 0;
            if (req != 0 && (e_code + req < 0 || e_code + req > 63)) begin
               m_sat++;
               if (m_sat == 3) begin m_ph = 5; e_errr = 1; e_busy = 0; e_locked = 0; end
               return;
            end
            m_sat = 0;
            if (req == 0) begin
               good = 1; m_run = 0;
            end else begin
               good = (req != m_last);
               m_run = (req == m_last) ? m_run + 1 : 1;
               m_last = req;
               e_code += req;
            end
            if (m_ph == 3) begin
               m_cnt = good ? m_cnt + 1 : 0;
               if (m_cnt == 8) begin m_ph = 4; e_locked = 1; e_busy = 0; end
            end else if (m_run >= 3) begin
               m_ph = 3; e_locked = 0; e_busy = 1; m_cnt = 0;
            end
         end
         default: ;
      endcase
   endtask

   always @(posedge clk_ext or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   always @(negedge clk_ext) begin
      if (chk_en) begin
         n_tests++;
         if ({dly_code, Sel, locked, busy, err_cfg, err_range} !==
             {e_code[5:0], e_sel[1:0], e_locked[0], e_busy[0], e_errc[0], e_errr[0]}) begin
            n_fail++;
            $display("FAIL outputs t=%0t got code=%0d sel=%0d lk=%b busy=%b ecfg=%b erng=%b expected code=%0d sel=%0d lk=%0d busy=%0d ecfg=%0d erng=%0d",
                     $time, dly_code, Sel, locked, busy, err_cfg, err_range,
                     e_code, e_sel, e_locked, e_busy, e_errc, e_errr);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_pd();
      case (pd_mode)
         0: begin pd_up = (e_code < tgt); pd_dn = (e_code >= tgt); end
         1: begin pd_up = 1'b1; pd_dn = 1'b0; end
         2: begin pd_up = 1'b0; pd_dn = 1'b1; end
         default: begin pd_up = 1'($urandom_range(0, 1)); pd_dn = 1'($urandom_range(0, 1)); end
      endcase
   endtask

   task automatic tick();
      @(posedge clk_ext);
      #2;
      drive_pd();
   endtask

   task automatic do_reset(input int n, input int m);
      rst_n = 1'b0; N = 4'(n); M = 2'(m); freeze = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_locked(input logic want, input int limit, input string name);
      int k = 0;
      while (locked !== want && k < limit) begin tick(); k++; end
      check(name, int'(locked === want), 1);
   endtask

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;

      // illegal N: error reported on the second edge after release
      do_reset(0, 3);
      tick(); check("cfg_edge1_err", err_cfg, 0);
      tick(); check("cfg_edge2_err", err_cfg, 1);
      check("cfg_busy", busy, 0);
      check("cfg_code", dly_code, 0);

      // SAR to T=37, then lock
      pd_mode = 0; tgt = 37;
      do_reset(10, 3);
      tick(); tick();
      check("sar_first_trial", dly_code, 32);
      check("sar_busy", busy, 1);
      repeat (24) tick();
      check("sar_result", dly_code, 36);
      check("sar_model_pin", e_code, 36);
      check("sel_m3", Sel, 2);
      repeat (32) tick();
      check("lock_after_8", locked, 1);
      check("lock_busy", busy, 0);

      // target jump: unlock and relock at 44/45
      tgt = 45; drive_pd();
      wait_locked(1'b0, 40, "unlock_t45");
      wait_locked(1'b1, 150, "relock_t45");
      check("relock_code", int'(dly_code == 6'd44 || dly_code == 6'd45), 1);

      // freeze holds everything while the PD says move
      freeze = 1'b1; tgt = 20; drive_pd();
      saved = e_code;
      repeat (100) tick();
      check("freeze_code", dly_code, saved);
      check("freeze_locked", locked, 1);
      freeze = 1'b0;
      begin
         int k = 0;
         while (dly_code >= 6'(saved) && k < 20) begin tick(); k++; end
         check("freeze_resume_down", int'(dly_code < 6'(saved)), 1);
      end

      // M change while frozen takes priority, then SAR restarts; reset mid-SAR
      wait_locked(1'b1, 400, "relock_t20");
      freeze = 1'b1; M = 2'd2;
      tick();
      check("mchg_locked", locked, 0);
      check("mchg_code", dly_code, 0);
      check("mchg_sel", Sel, 1);
      freeze = 1'b0;
      tick();
      check("mchg_restart_busy", busy, 1);
      check("mchg_restart_code", dly_code, 32);
      repeat (6) tick();
      #1 rst_n = 1'b0;
      #1 check("async_reset_outputs", int'({dly_code, Sel, locked, busy, err_cfg, err_range}), 0);
      tick(); rst_n = 1'b1;

      // stuck up: saturate at 63 and fault, then recover via M change
      pd_mode = 1;
      do_reset(10, 3);
      tick(); tick();
      repeat (24) tick();
      check("stuck_sar_code", dly_code, 63);
      repeat (12) tick();
      check("stuck_err_range", err_range, 1);
      check("stuck_code_held", dly_code, 63);
      check("stuck_busy", busy, 0);
      M = 2'd2;
      tick();
      check("fault_exit_err", err_range, 0);
      check("fault_exit_code", dly_code, 0);
      check("fault_exit_sel", Sel, 1);
      tick();
      check("fault_exit_restart", busy, 1);

      // randomized operation against the model
      do_reset(10, 3);
      for (int c = 0; c < 4000; c++) begin
         if (c % 150 == 0) begin
            pd_mode = $urandom_range(0, 3);
            tgt     = $urandom_range(0, 64);
         end
         if ($urandom_range(0, 31) == 0) freeze = ~freeze;
         if ($urandom_range(0, 399) == 0) begin
            N = 4'($urandom_range(0, 12));
            M = 2'($urandom_range(0, 3));
         end
         drive_pd();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
